// File: rtl/sram_axi_rd_arb.sv
// sram_axi_rd_arb: schedules two SRAM-like read ports onto one AXI3 AR/R pair; single-beat reads, one outstanding per port.
// Latency: addr_ok in the request cycle (IDLE), AR valid the next cycle; data_ok in the same cycle as the R beat.
// Backpressure: arready low holds AR stable and blocks further addr_ok; rready is always high. RD_ARB_RR_EN selects round-robin.
module sram_axi_rd_arb #(
    parameter logic [3:0] ID_P1 = 4'd0,
    parameter logic [3:0] ID_P2 = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s1_req,
    input  logic [1:0]  s1_size,
    input  logic [31:0] s1_addr,
    output logic        s1_addr_ok,
    output logic        s1_data_ok,
    output logic [31:0] s1_rdata,
    input  logic        s2_req,
    input  logic [1:0]  s2_size,
    input  logic [31:0] s2_addr,
    output logic        s2_addr_ok,
    output logic        s2_data_ok,
    output logic [31:0] s2_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t state;
    logic   out1, out2;
    logic   elig1, elig2, pick2;
    logic   grant1, grant2;
    logic   unused_r;

    assign elig1 = s1_req & ~out1;
    assign elig2 = s2_req & ~out2;

`ifdef RD_ARB_RR_EN
    logic last_grant;  // 0 = port 1, 1 = port 2

    // On a conflict the port that was not granted last time wins.
    assign pick2 = elig2 & (~elig1 | ~last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b0;
        end else if (grant1 | grant2) begin
            last_grant <= grant2;
        end
    end
`else
    assign pick2 = elig2;
`endif

    assign grant2 = rst_n & (state == IDLE) & pick2;
    assign grant1 = rst_n & (state == IDLE) & elig1 & ~pick2;

    assign s1_addr_ok = grant1;
    assign s2_addr_ok = grant2;

    assign s1_data_ok = rst_n & rvalid & (rid == ID_P1) & out1;
    assign s2_data_ok = rst_n & rvalid & (rid == ID_P2) & out2;
    assign s1_rdata   = rdata;
    assign s2_rdata   = rdata;
    assign rready     = rst_n;

    // Single-beat INCR reads only; response code and rlast carry no information here.
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign unused_r = ^{rresp, rlast};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            arvalid <= 1'b0;
            araddr  <= 32'd0;
            arid    <= 4'd0;
            arsize  <= 3'd0;
            out1    <= 1'b0;
            out2    <= 1'b0;
        end else begin
            out1 <= (out1 & ~s1_data_ok) | grant1;
            out2 <= (out2 & ~s2_data_ok) | grant2;
            case (state)
                IDLE: begin
                    if (grant1 | grant2) begin
                        araddr  <= grant2 ? s2_addr : s1_addr;
                        arsize  <= {1'b0, grant2 ? s2_size : s1_size};
                        arid    <= grant2 ? ID_P2 : ID_P1;
                        arvalid <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
